// File: rtl/montgomery_const_gen_if.sv
// Start/done handshake and result bus of montgomery_const_gen.
// MONT_NPRIME_EN adds the NP_WIDTH parameter and the n_prime result.
interface montgomery_const_gen_if #(
    parameter int WIDTH = 1024
`ifdef MONT_NPRIME_EN
    , parameter int NP_WIDTH = 32
`endif
);
    logic             start;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] r_mod;
    logic [WIDTH-1:0] r2_mod;
`ifdef MONT_NPRIME_EN
    logic [NP_WIDTH-1:0] n_prime;

    modport master (output start, modulus, input busy, done, err, r_mod, r2_mod, n_prime);
    modport slave  (input start, modulus, output busy, done, err, r_mod, r2_mod, n_prime);
`else
    modport master (output start, modulus, input busy, done, err, r_mod, r2_mod);
    modport slave  (input start, modulus, output busy, done, err, r_mod, r2_mod);
`endif
endinterface

// File: rtl/montgomery_const_gen.sv
// Montgomery constants R mod M and R^2 mod M by bit-serial modular doubling (R = 2^WIDTH).
// MONT_NPRIME_EN also derives n' = -M^-1 mod 2^NP_WIDTH during the same run.
module montgomery_const_gen #(
    parameter int WIDTH = 1024
`ifdef MONT_NPRIME_EN
    , parameter int NP_WIDTH = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    montgomery_const_gen_if.slave bus
);
    localparam int CW = $clog2(2 * WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] r_mod_q, r_mod_d;
    logic [WIDTH-1:0] r2_mod_q, r2_mod_d;
    logic [WIDTH:0]   dbl;
`ifdef MONT_NPRIME_EN
    logic [NP_WIDTH-1:0] u_q, u_d;
    logic [NP_WIDTH-1:0] n_prime_q, n_prime_d;
    logic [NP_WIDTH-1:0] bit_sel;
`endif

    assign dbl = acc_q << 1;
`ifdef MONT_NPRIME_EN
    // Shifts past NP_WIDTH-1 yield zero, so steps beyond NP_WIDTH leave u and n' alone.
    assign bit_sel = NP_WIDTH'(1) << cnt_q;
`endif

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        r_mod_d  = r_mod_q;
        r2_mod_d = r2_mod_q;
`ifdef MONT_NPRIME_EN
        u_d       = u_q;
        n_prime_d = n_prime_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.modulus[0]) begin
                        m_d     = bus.modulus;
                        // Seed with 1 mod M so that M=1 stays at zero instead of sticking at 1.
                        acc_d   = (bus.modulus == WIDTH'(1)) ? '0 : (WIDTH + 1)'(1);
                        cnt_d   = '0;
                        state_d = RUN;
`ifdef MONT_NPRIME_EN
                        u_d       = NP_WIDTH'(1);
                        n_prime_d = '0;
`endif
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                acc_d = (dbl >= {1'b0, m_q}) ? dbl - {1'b0, m_q} : dbl;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    r_mod_d = acc_d[WIDTH-1:0];
                end
                if (cnt_q == CW'(2 * WIDTH - 1)) begin
                    r2_mod_d = acc_d[WIDTH-1:0];
                    done_d   = 1'b1;
                    state_d  = FIN;
                end
`ifdef MONT_NPRIME_EN
                if ((u_q & bit_sel) != '0) begin
                    n_prime_d = n_prime_q | bit_sel;
                    u_d       = u_q + (m_q[NP_WIDTH-1:0] << cnt_q);
                end
`endif
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            r_mod_q  <= '0;
            r2_mod_q <= '0;
`ifdef MONT_NPRIME_EN
            u_q       <= '0;
            n_prime_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            r_mod_q  <= r_mod_d;
            r2_mod_q <= r2_mod_d;
`ifdef MONT_NPRIME_EN
            u_q       <= u_d;
            n_prime_q <= n_prime_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.r_mod  = r_mod_q;
    assign bus.r2_mod = r2_mod_q;
`ifdef MONT_NPRIME_EN
    assign bus.n_prime = n_prime_q;
`endif
endmodule

// File: tb/tb_montgomery_const_gen.sv
// Bench for montgomery_const_gen: directed table, random jobs against an arithmetic model,
// mid-run reset, held start, and one full-width 1024-bit job.
module tb_montgomery_const_gen;
    localparam int W   = 8;
    localparam int NPW = 8;
    localparam int BW  = 1024;
    localparam int BNP = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef MONT_NPRIME_EN
    montgomery_const_gen_if #(.WIDTH(W), .NP_WIDTH(NPW)) bus ();
    montgomery_const_gen    #(.WIDTH(W), .NP_WIDTH(NPW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    montgomery_const_gen_if #(.WIDTH(BW), .NP_WIDTH(BNP)) bbus ();
    montgomery_const_gen    #(.WIDTH(BW), .NP_WIDTH(BNP)) bdut (.clk(clk), .rst_n(rst_n), .bus(bbus));
`else
    montgomery_const_gen_if #(.WIDTH(W)) bus ();
    montgomery_const_gen    #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    montgomery_const_gen_if #(.WIDTH(BW)) bbus ();
    montgomery_const_gen    #(.WIDTH(BW)) bdut (.clk(clk), .rst_n(rst_n), .bus(bbus));
`endif

    int checks = 0;
    int errors = 0;
    int prev_r = 0, prev_r2 = 0, prev_np = 0;

    typedef struct {
        int m;
        int r;
        int r2;
        int np;
        bit err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic and a brute-force inverse search.
    task automatic model(input int m, output int r, output int r2, output int np);
        longint rr;
        rr = longint'(1) << W;
        r  = int'(rr % m);
        rr = longint'(1) << (2 * W);
        r2 = int'(rr % m);
        np = 0;
        for (int n = 0; n < (1 << NPW); n++)
            if (((m * n) & ((1 << NPW) - 1)) == ((1 << NPW) - 1)) np = n;
    endtask

    // Issue one job from IDLE and check latency, busy span, results and the done pulse.
    task automatic run_job(input int m, input int er, input int er2, input int enp,
                           input bit eerr, input string tag);
        int lat;
        int nb;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = W'(m);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        nb  = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.busy) nb++;
        end
        chk({tag, " latency"}, 64'(lat), eerr ? 64'd1 : 64'(2 * W + 1));
        chk({tag, " busy_cycles"}, 64'(nb), eerr ? 64'd1 : 64'(2 * W + 1));
        chk({tag, " err"}, 64'(bus.err), 64'(eerr));
        chk({tag, " r_mod"}, 64'(bus.r_mod), 64'(er));
        chk({tag, " r2_mod"}, 64'(bus.r2_mod), 64'(er2));
`ifdef MONT_NPRIME_EN
        chk({tag, " n_prime"}, 64'(bus.n_prime), 64'(enp));
`endif
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, " busy_clear"}, 64'(bus.busy), 64'd0);
        prev_r  = er;
        prev_r2 = er2;
        prev_np = enp;
        $display("job %s M=%0d lat=%0d r_mod=%0d r2_mod=%0d err=%0d", tag, m, lat,
                 bus.r_mod, bus.r2_mod, bus.err);
    endtask

    initial begin
        vec_t vecs[5];
        int   er, er2, enp, m, lat, ndone;

        vecs[0] = '{m: 13,  r: 9,  r2: 3,   np: 59,  err: 1'b0};
        vecs[1] = '{m: 241, r: 15, r2: 225, np: 239, err: 1'b0};
        vecs[2] = '{m: 255, r: 1,  r2: 1,   np: 1,   err: 1'b0};
        vecs[3] = '{m: 12,  r: 1,  r2: 1,   np: 1,   err: 1'b1};
        vecs[4] = '{m: 1,   r: 0,  r2: 0,   np: 255, err: 1'b0};

        bus.start    = 1'b0;
        bus.modulus  = '0;
        bbus.start   = 1'b0;
        bbus.modulus = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset err", 64'(bus.err), 64'd0);
        chk("reset r_mod", 64'(bus.r_mod), 64'd0);
        chk("reset r2_mod", 64'(bus.r2_mod), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_job(vecs[i].m, vecs[i].r, vecs[i].r2, vecs[i].np, vecs[i].err, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            m = $urandom_range(1, 255);
            if ($urandom_range(0, 4) == 0) m = m & 32'hFE;
            if (m % 2 == 0) begin
                er = prev_r; er2 = prev_r2; enp = prev_np;
            end else begin
                model(m, er, er2, enp);
            end
            run_job(m, er, er2, enp, (m % 2) == 0, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a run: outputs drop at once and no done follows.
        run_job(13, 9, 3, 59, 1'b0, "pre_reset");
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = W'(13);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset done", 64'(bus.done), 64'd0);
        chk("midreset r_mod", 64'(bus.r_mod), 64'd0);
        chk("midreset r2_mod", 64'(bus.r2_mod), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midreset no_done", 64'(ndone), 64'd0);
        $display("job midreset done_count=%0d", ndone);
        run_job(13, 9, 3, 59, 1'b0, "post_reset");

        // Start held high with the modulus changed mid-run.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.modulus = W'(13);
        lat   = 0;
        ndone = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 5) bus.modulus = W'(11);
        end while (!bus.done && lat < 100);
        chk("hold latency", 64'(lat), 64'(2 * W + 1));
        chk("hold r_mod", 64'(bus.r_mod), 64'd9);
        chk("hold r2_mod", 64'(bus.r2_mod), 64'd3);
        @(negedge clk);
        chk("hold idle_gap busy", 64'(bus.busy), 64'd0);
        chk("hold idle_gap done", 64'(bus.done), 64'd0);
        @(negedge clk);
        chk("hold reaccept busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        model(11, er, er2, enp);
        chk("hold2 latency", 64'(lat), 64'(2 * W + 1));
        chk("hold2 r_mod", 64'(bus.r_mod), 64'(er));
        chk("hold2 r2_mod", 64'(bus.r2_mod), 64'(er2));
`ifdef MONT_NPRIME_EN
        chk("hold2 n_prime", 64'(bus.n_prime), 64'(enp));
`endif
        $display("job hold M=11 lat=%0d r_mod=%0d r2_mod=%0d", lat, bus.r_mod, bus.r2_mod);
        @(negedge clk);

        // Full-width job: M = 2^1024 - 1.
        bbus.start   = 1'b1;
        bbus.modulus = '1;
        @(negedge clk);
        bbus.start = 1'b0;
        lat = 1;
        while (!bbus.done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk("big latency", 64'(lat), 64'(2 * BW + 1));
        chk("big r_mod_lo", bbus.r_mod[63:0], 64'd1);
        chk("big r_mod_hi", 64'(|bbus.r_mod[BW-1:64]), 64'd0);
        chk("big r2_mod_lo", bbus.r2_mod[63:0], 64'd1);
        chk("big r2_mod_hi", 64'(|bbus.r2_mod[BW-1:64]), 64'd0);
        chk("big err", 64'(bbus.err), 64'd0);
`ifdef MONT_NPRIME_EN
        chk("big n_prime", 64'(bbus.n_prime), 64'd1);
`endif
        $display("job big lat=%0d r_mod_lo=%0d r2_mod_lo=%0d", lat, bbus.r_mod[63:0], bbus.r2_mod[63:0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/montgomery_const_gen.md
# montgomery_const_gen

Parametrised, multi-cycle generator of the Montgomery domain constants for an odd modulus M of WIDTH bits, with R = 2^WIDTH. Produces R mod M and R^2 mod M by bit-serial modular doubling, and optionally the word constant n' = -M^-1 mod 2^NP_WIDTH. Sits ahead of the modular multiplier in the RSA decryption datapath and runs once per key load, under a start/done handshake.

## Interface
- WIDTH, 1024: modulus and result width in bits; R = 2^WIDTH; minimum 4.
- NP_WIDTH, 32: width of n'; only used with MONT_NPRIME_EN; requires NP_WIDTH <= WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request; acted on only in IDLE.
- modulus  input  WIDTH  modulus M; captured on the accepting edge.
- busy  output  1  high from the accepting edge until the done cycle, inclusive.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with done, when M was even.
- r_mod  output  WIDTH  R mod M.
- r2_mod  output  WIDTH  R^2 mod M.
- n_prime  output  NP_WIDTH  -M^-1 mod 2^NP_WIDTH; present only with MONT_NPRIME_EN.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start=1, modulus[0]=1: capture M into m_q, acc <= 1 (WIDTH+1 bits), cnt <= 0, go to RUN.
- IDLE, start=1, modulus[0]=0: go to FIN with err flagged; r_mod, r2_mod and n_prime keep their previous values.
- RUN step, one per cycle: t = acc<<1; acc <= (t >= m_q) ? t - m_q : t; cnt <= cnt+1.
- Invariant acc < M, so t < 2M fits in WIDTH+1 bits and one subtraction suffices.
- After step WIDTH (cnt transitions WIDTH-1 -> WIDTH): r_mod <= new acc value.
- After step 2*WIDTH: r2_mod <= new acc value, go to FIN.
- FIN: done=1, err as flagged; next state IDLE unconditionally.
- start while busy is ignored, including in FIN; modulus changes after capture have no effect.
- M=1: all results 0, no error.
- Outputs are only rewritten at the points above and hold otherwise.

## Timing
- Reset (asynchronous, any state): state IDLE, busy=0, done=0, err=0, r_mod=0, r2_mod=0, n_prime=0, acc=0, cnt=0. Reset mid-run abandons the computation with no done pulse.
- Accepting edge E0 → busy high after E0.
- Valid modulus: RUN steps at E1..E2W; r_mod valid after EW, r2_mod valid after E2W; done/busy high during the cycle after E2W; IDLE after E(2W+1). Latency start→done = 2*WIDTH+1 cycles.
- Even modulus: done=err=1 during the cycle after E0; IDLE after E1.
- A new start may be accepted on the edge where FIN returns to IDLE only if it is still high in the following IDLE cycle (one idle cycle minimum between jobs).

## Configuration
- MONT_NPRIME_EN defined: NP_WIDTH-bit register u starts at 1 and n_prime at 0 on accept. During RUN steps i = 0..NP_WIDTH-1, if u[i]=1 then n_prime[i] <= 1 and u <= u + (m_q << i) mod 2^NP_WIDTH. n_prime is final after step NP_WIDTH and so valid at done. There is no extra latency.
- MONT_NPRIME_EN undefined: no n_prime port, no u register, no adder. All other behaviour is identical.

## Test plan
- WIDTH=8, M=13: done exactly 17 cycles after the accepting edge → r_mod=9, r2_mod=3, n_prime=59 (NP_WIDTH=8); busy high for 17 cycles.
- WIDTH=8, M=241 then M=255 back-to-back → r_mod=15, r2_mod=225; then r_mod=1, r2_mod=1; each job takes 17 cycles.
- WIDTH=8, M=12 → done=err=1 one cycle after accept; r_mod and r2_mod still hold the previous job's values. Then M=1 → r_mod=0, r2_mod=0, err=0.
- WIDTH=8, M=13: pulse rst_n low at cycle 6 of RUN → all outputs 0 immediately, no done. A fresh start → correct results after 17 cycles.
- WIDTH=8: start held high and modulus changed to 11 mid-run → results still correspond to 13; exactly one done, followed by one idle cycle before the next accept.
- WIDTH=1024, M=2^1024-1 → r_mod=1, r2_mod=1, n_prime=1 (NP_WIDTH=32); done 2049 cycles after accept.
